// File: rtl/apb_cmd_master_if.sv
// Command stream, response stream and APB3 bus signals of apb_cmd_master.
// master: the initiator's view (drives APB and the handshake outputs).
// slave:  the surrounding environment's view (command source, response sink, completer).
interface apb_cmd_master_if;
    // Command channel
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        cmd_write;
    // Response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    // APB3 bus
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_wdata, cmd_write,
        output cmd_ready,
        input  rsp_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_wdata, cmd_write,
        input  cmd_ready,
        output rsp_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 initiator: converts valid/ready commands into single APB transfers,
// one in flight at a time, and returns each result on a valid/ready response
// channel. Transfers whose completer never raises pready are aborted after
// TIMEOUT ACCESS cycles (TIMEOUT = 0 disables the abort).
module apb_cmd_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rstn,
    apb_cmd_master_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

    state_t      state_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        rsp_timeout_q;
    logic [31:0] paddr_q;
    logic        psel_q;
    logic        penable_q;
    logic        pwrite_q;
    logic [31:0] pwdata_q;
    logic [15:0] wait_cnt_q;
    logic        timeout_hit;

    // The counter holds the number of completed ACCESS cycles, so the current
    // cycle is the TIMEOUT-th one when wait_cnt_q + 1 reaches TIMEOUT.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (({1'b0, wait_cnt_q} + 17'd1) >= TIMEOUT_W);
    end

    // Transfer sequencing with registered handshake, response and APB outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            paddr_q       <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            wait_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // cmd_ready comes up one edge after reset release; a
                    // command is only taken once it is visible as high.
                    if (!cmd_ready_q) begin
                        cmd_ready_q <= 1'b1;
                    end else if (bus.cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        paddr_q     <= bus.cmd_addr;
                        pwdata_q    <= bus.cmd_wdata;
                        pwrite_q    <= bus.cmd_write;
                        psel_q      <= 1'b1;
                        wait_cnt_q  <= '0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (wait_cnt_q != '1) begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                    if (bus.pready) begin
                        rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
                        rsp_err_q     <= bus.pslverr;
                        rsp_timeout_q <= 1'b0;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    // Raising cmd_ready here lets the next command be taken on
                    // the first IDLE edge, giving a 4-cycle command period.
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.paddr       = paddr_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed scenarios followed by random transfers,
// with expected responses taken from a transfer-level model of the block.
module tb_apb_cmd_master;

    localparam int unsigned TMO = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    apb_cmd_master_if bus ();

    apb_cmd_master #(.TIMEOUT(TMO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int unsigned acc;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    // Transfer-level outcome: a completer that stalls for `waits` ACCESS
    // cycles either answers on cycle waits+1 or is cut off after TMO cycles.
    function automatic exp_t model(input logic wr, input int unsigned waits,
                                   input logic [31:0] prd, input logic slv);
        exp_t e;
        if (TMO != 0 && waits >= TMO) begin
            e.acc = TMO; e.rdata = '0; e.err = 1'b1; e.tmo = 1'b1;
        end else begin
            e.acc = waits + 1; e.rdata = wr ? 32'h0 : prd; e.err = slv; e.tmo = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one command from a negedge to the negedge after its response handshake.
    task automatic run_txn(input string nm, input logic [31:0] addr, input logic [31:0] wd,
                           input logic wr, input int unsigned waits, input logic [31:0] prd,
                           input logic slv, input int unsigned hold, input logic pre_en,
                           input logic [31:0] pre_addr, input logic [31:0] pre_wd,
                           input logic pre_wr);
        exp_t        e;
        int unsigned n;
        int unsigned k;
        e = model(wr, waits, prd, slv);

        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.cmd_write = wr;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check({nm, "/cmd_ready_wait"}, 32'(bus.cmd_ready), 32'h1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        bus.cmd_write = 1'($urandom_range(0, 1));

        // SETUP cycle
        check({nm, "/setup_psel"},    32'(bus.psel),      32'h1);
        check({nm, "/setup_penable"}, 32'(bus.penable),   32'h0);
        check({nm, "/setup_cmd_rdy"}, 32'(bus.cmd_ready), 32'h0);
        check({nm, "/paddr"},         bus.paddr,          addr);
        check({nm, "/pwdata"},        bus.pwdata,         wd);
        check({nm, "/pwrite"},        32'(bus.pwrite),    32'(wr));
        @(negedge clk);

        // ACCESS cycles: completer stalls for `waits` cycles then answers
        k = 0;
        while (bus.psel === 1'b1 && bus.penable === 1'b1 && k < 80) begin
            if (bus.paddr !== addr || bus.pwdata !== wd || bus.pwrite !== wr)
                check({nm, "/access_stable"}, bus.paddr, addr);
            bus.pready  = (k == waits);
            bus.prdata  = (k == waits) ? prd : $urandom;
            bus.pslverr = (k == waits) ? slv : 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        bus.pready  = 1'b0;
        bus.prdata  = $urandom;
        bus.pslverr = 1'($urandom_range(0, 1));
        check({nm, "/access_cycles"}, 32'(k), 32'(e.acc));

        // RESP cycle(s)
        check({nm, "/rsp_valid"},   32'(bus.rsp_valid),   32'h1);
        check({nm, "/resp_psel"},   32'(bus.psel),        32'h0);
        check({nm, "/resp_pen"},    32'(bus.penable),     32'h0);
        check({nm, "/rsp_rdata"},   bus.rsp_rdata,        e.rdata);
        check({nm, "/rsp_err"},     32'(bus.rsp_err),     32'(e.err));
        check({nm, "/rsp_timeout"}, 32'(bus.rsp_timeout), 32'(e.tmo));
        if (pre_en) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_addr  = pre_addr;
            bus.cmd_wdata = pre_wd;
            bus.cmd_write = pre_wr;
        end
        for (int unsigned h = 0; h < hold; h++) begin
            bus.rsp_ready = 1'b0;
            @(negedge clk);
            bus.prdata  = $urandom;
            bus.pslverr = 1'($urandom_range(0, 1));
            check({nm, "/hold_valid"},   32'(bus.rsp_valid), 32'h1);
            check({nm, "/hold_rdata"},   bus.rsp_rdata,      e.rdata);
            check({nm, "/hold_err"},     32'(bus.rsp_err),   32'(e.err));
            check({nm, "/hold_tmo"},     32'(bus.rsp_timeout), 32'(e.tmo));
            check({nm, "/hold_cmd_rdy"}, 32'(bus.cmd_ready), 32'h0);
            check({nm, "/hold_psel"},    32'(bus.psel),      32'h0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({nm, "/post_valid"},   32'(bus.rsp_valid), 32'h0);
        check({nm, "/post_cmd_rdy"}, 32'(bus.cmd_ready), 32'h1);
        check({nm, "/post_paddr"},   bus.paddr,          addr);
        check({nm, "/post_psel"},    32'(bus.psel),      32'h0);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_write = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        // Reset values while rstn is low
        #12;
        check("rst/cmd_ready",   32'(bus.cmd_ready),   32'h0);
        check("rst/rsp_valid",   32'(bus.rsp_valid),   32'h0);
        check("rst/rsp_rdata",   bus.rsp_rdata,        32'h0);
        check("rst/rsp_err",     32'(bus.rsp_err),     32'h0);
        check("rst/rsp_timeout", 32'(bus.rsp_timeout), 32'h0);
        check("rst/paddr",       bus.paddr,            32'h0);
        check("rst/psel",        32'(bus.psel),        32'h0);
        check("rst/penable",     32'(bus.penable),     32'h0);
        check("rst/pwrite",      32'(bus.pwrite),      32'h0);
        check("rst/pwdata",      bus.pwdata,           32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("rst/cmd_ready_rise", 32'(bus.cmd_ready), 32'h1);

        // Directed scenarios
        run_txn("zw_write", 32'h08, 32'hDEADBEEF, 1'b1, 0, 32'hA5A5A5A5, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        run_txn("rd_3wait", 32'h0C, 32'h0, 1'b0, 3, 32'h12345678, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        run_txn("rd_slverr", 32'h04, 32'h0, 1'b0, 0, 32'hCAFEF00D, 1'b1, 0, 1'b0, '0, '0, 1'b0);
        run_txn("timeout", 32'h10, 32'h0, 1'b0, 100, 32'h11111111, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        run_txn("rdy_at_tmo", 32'h10, 32'h0, 1'b0, TMO - 1, 32'h87654321, 1'b0, 0, 1'b0, '0, '0, 1'b0);
        run_txn("bp_first", 32'h14, 32'h0010, 1'b1, 0, 32'h0, 1'b0, 5, 1'b1, 32'h18, 32'h0003, 1'b1);
        run_txn("bp_second", 32'h18, 32'h0003, 1'b1, 0, 32'h0, 1'b0, 0, 1'b0, '0, '0, 1'b0);

        // Reset in the middle of a wait-stated read
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h0C;
        bus.cmd_wdata = 32'h0;
        bus.cmd_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.pready    = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst/in_access", 32'(bus.penable), 32'h1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst/psel",      32'(bus.psel),      32'h0);
        check("mid_rst/penable",   32'(bus.penable),   32'h0);
        check("mid_rst/rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("mid_rst/cmd_ready", 32'(bus.cmd_ready), 32'h0);
        check("mid_rst/paddr",     bus.paddr,          32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("mid_rst/no_rsp",    32'(bus.rsp_valid), 32'h0);
        check("mid_rst/cmd_ready", 32'(bus.cmd_ready), 32'h1);
        run_txn("after_rst", 32'h00, 32'h0000BEEF, 1'b1, 1, 32'h0, 1'b0, 1, 1'b0, '0, '0, 1'b0);

        // Random transfers
        for (int i = 0; i < 30; i++) begin
            run_txn($sformatf("rnd%0d", i), $urandom, $urandom, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 11), $urandom, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'b0, '0, '0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
